// File: rtl/instr_encode.sv
// RV32I instruction encoder: assembles field beats into machine words
// and streams them to sequential memory addresses.
module instr_encode (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [31:0] i_base_addr,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [3:0]  i_code,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7_b5,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  input  logic        i_wr_ready,
  output logic        o_busy,
  output logic [15:0] o_count,
  output logic        o_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  state_t      state;
  state_t      state_nx;
  logic        out_valid;
  logic [31:0] ptr;
  logic        accept;
  logic        retire;
  logic        legal;
  logic [31:0] word;
  logic        open_s;

  assign o_we   = out_valid;
  assign retire = out_valid && i_wr_ready;
  assign accept = i_valid && o_ready;
  assign open_s = (state == IDLE) && i_start;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Session sequencing and handshake outputs
  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_busy   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) state_nx = RUN;
      end
      RUN: begin
        o_busy  = 1'b1;
        o_ready = !out_valid || i_wr_ready;
        if (i_stop) state_nx = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (!out_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Field-to-word assembly per instruction class
  always_comb begin
    legal = 1'b1;
    word  = '0;
    unique case (i_code)
      4'd1: word = {1'b0, i_funct7_b5, 5'b0, i_rs2,
                    i_rs1, i_funct3, i_rd, OP_R};
      4'd2: begin
        word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I};
        if (i_funct3 == 3'b001 || i_funct3 == 3'b101)
          word[31:20] = {1'b0, i_funct7_b5, 5'b0, i_imm[4:0]};
      end
      4'd3: word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LD};
      4'd4: word = {i_imm[11:5], i_rs2, i_rs1, i_funct3,
                    i_imm[4:0], OP_S};
      4'd5: word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1,
                    i_funct3, i_imm[4:1], i_imm[11], OP_B};
      4'd6: word = {i_imm[20], i_imm[10:1], i_imm[11],
                    i_imm[19:12], i_rd, OP_J};
      4'd7: word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_JALR};
      4'd8: word = {i_imm[31:12], i_rd, OP_LUI};
      4'd9: word = {i_imm[31:12], i_rd, OP_AUI};
      default: legal = 1'b0;
    endcase
  end

  // Output stage, address pointer, counters and sticky error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid <= 1'b0;
      ptr       <= '0;
      o_addr    <= '0;
      o_wdata   <= '0;
      o_count   <= '0;
      o_err     <= 1'b0;
    end else if (open_s) begin
      ptr     <= i_base_addr;
      o_count <= '0;
      o_err   <= 1'b0;
    end else begin
      if (retire) begin
        ptr <= ptr + 32'd4;
        if (o_count != 16'hFFFF) o_count <= o_count + 16'd1;
      end
      if (accept && legal) begin
        out_valid <= 1'b1;
        o_addr    <= retire ? ptr + 32'd4 : ptr;
        o_wdata   <= word;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
      if (accept && !legal) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encode.sv
// Randomized bench for instr_encode against a transaction-level
// reference model, with literal encodings pinned from known words.
module tb_instr_encode;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [31:0] base;
  logic        valid;
  logic        ready;
  logic [3:0]  code;
  logic [2:0]  f3;
  logic        f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr_ready;
  logic        busy;
  logic [15:0] count;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  instr_encode dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_stop      (stop),
    .i_base_addr (base),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_code      (code),
    .i_funct3    (f3),
    .i_funct7_b5 (f7),
    .i_rd        (rd),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .i_imm       (imm),
    .o_we        (we),
    .o_addr      (addr),
    .o_wdata     (wdata),
    .i_wr_ready  (wr_ready),
    .o_busy      (busy),
    .o_count     (count),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] c);
    return c >= 4'd1 && c <= 4'd9;
  endfunction

  // Reference encoder built from bit-field shifts and masks
  function automatic logic [31:0] ref_enc(
    input logic [3:0] c, input logic [2:0] fn3,
    input logic fn7, input logic [4:0] d_r,
    input logic [4:0] s_1, input logic [4:0] s_2,
    input logic [31:0] im);
    logic [31:0] w, r2, r1, f, d, i12, hi7;
    r2  = {27'd0, s_2} << 20;
    r1  = {27'd0, s_1} << 15;
    f   = {29'd0, fn3} << 12;
    d   = {27'd0, d_r} << 7;
    i12 = (im & 32'hFFF) << 20;
    hi7 = {31'd0, fn7} << 30;
    case (c)
      4'd1: w = hi7 | r2 | r1 | f | d | 32'h33;
      4'd2: begin
        if (fn3 == 3'd1 || fn3 == 3'd5)
          w = hi7 | ((im & 32'h1F) << 20) | r1 | f | d | 32'h13;
        else
          w = i12 | r1 | f | d | 32'h13;
      end
      4'd3: w = i12 | r1 | f | d | 32'h03;
      4'd4: w = (((im >> 5) & 32'h7F) << 25) | r2 | r1 | f
              | ((im & 32'h1F) << 7) | 32'h23;
      4'd5: w = (((im >> 12) & 32'h1) << 31)
              | (((im >> 5) & 32'h3F) << 25) | r2 | r1 | f
              | (((im >> 1) & 32'hF) << 8)
              | (((im >> 11) & 32'h1) << 7) | 32'h63;
      4'd6: w = (((im >> 20) & 32'h1) << 31)
              | (((im >> 1) & 32'h3FF) << 21)
              | (((im >> 11) & 32'h1) << 20)
              | (((im >> 12) & 32'hFF) << 12) | d | 32'h6F;
      4'd7: w = i12 | r1 | f | d | 32'h67;
      4'd8: w = (im & 32'hFFFFF000) | d | 32'h37;
      4'd9: w = (im & 32'hFFFFF000) | d | 32'h17;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Model state: mode 0 idle, 1 run, 2 drain
  int          m_mode;
  bit          m_pend;
  logic [31:0] m_paddr;
  logic [31:0] m_pdata;
  logic [31:0] m_next;
  logic [15:0] m_count;
  bit          m_err;

  // Compare every cycle, then advance the model by one clock
  always @(negedge clk) begin : cmp
    bit er, ret, acc, pend0;
    if (!rst_n) begin
      m_mode  = 0;
      m_pend  = 0;
      m_next  = 0;
      m_count = 0;
      m_err   = 0;
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_count", {16'd0, count}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_addr", addr, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
    end else begin
      er = (m_mode == 1) && (!m_pend || wr_ready);
      chk("m_ready", {31'd0, ready}, {31'd0, er});
      chk("m_busy", {31'd0, busy}, {31'd0, m_mode != 0});
      chk("m_we", {31'd0, we}, {31'd0, m_pend});
      chk("m_count", {16'd0, count}, {16'd0, m_count});
      chk("m_err", {31'd0, err}, {31'd0, m_err});
      if (m_pend) begin
        chk("m_addr", addr, m_paddr);
        chk("m_wdata", wdata, m_pdata);
      end
      pend0 = m_pend;
      if (m_mode == 0) begin
        if (start) begin
          m_mode  = 1;
          m_next  = base;
          m_count = 0;
          m_err   = 0;
        end
      end else begin
        ret = m_pend && wr_ready;
        acc = valid && er;
        if (ret) begin
          m_next = m_next + 32'd4;
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          m_pend = 0;
        end
        if (acc) begin
          if (is_legal(code)) begin
            m_pend  = 1;
            m_paddr = m_next;
            m_pdata = ref_enc(code, f3, f7, rd, rs1, rs2, imm);
          end else begin
            m_err = 1;
          end
        end
        if (m_mode == 1 && stop) m_mode = 2;
        else if (m_mode == 2 && !pend0) m_mode = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] c, input logic [2:0] fn3,
                      input logic fn7, input logic [4:0] d_r,
                      input logic [4:0] s_1, input logic [4:0] s_2,
                      input logic [31:0] im);
    valid = 1'b1;
    code  = c;
    f3    = fn3;
    f7    = fn7;
    rd    = d_r;
    rs1   = s_1;
    rs2   = s_2;
    imm   = im;
  endtask

  initial begin : stim
    logic [31:0] a0, d0;
    logic [15:0] c0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; base = '0;
    valid = 1'b0; code = '0; f3 = '0; f7 = 1'b0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0; wr_ready = 1'b1;

    chk("pin_r", ref_enc(4'd1, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0),
        32'h002081B3);
    chk("pin_i", ref_enc(4'd2, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5),
        32'h00500093);
    chk("pin_s", ref_enc(4'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8),
        32'h0020A423);
    chk("pin_b", ref_enc(4'd5, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2,
        32'hFFFFFFFC), 32'hFE208EE3);
    chk("pin_u", ref_enc(4'd8, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0,
        32'h12345000), 32'h123452B7);
    chk("pin_j", ref_enc(4'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8),
        32'h008000EF);
    chk("pin_srai", ref_enc(4'd2, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0,
        32'hFFFFF7E3), 32'h40315093);

    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // First session: single R-type write
    start = 1'b1; base = 32'h100;
    cyc();
    start = 1'b0;
    beat(4'd1, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    cyc();
    valid = 1'b0;
    chk("r_we", {31'd0, we}, 32'd1);
    chk("r_addr", addr, 32'h100);
    chk("r_wdata", wdata, 32'h002081B3);
    cyc();
    chk("r_count", {16'd0, count}, 32'd1);

    // Close, reopen at same base, back-to-back beats
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; base = 32'h100;
    cyc();
    start = 1'b0;
    beat(4'd2, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    cyc();
    chk("i_wdata", wdata, 32'h00500093);
    chk("i_addr", addr, 32'h100);
    beat(4'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    cyc();
    chk("s_wdata", wdata, 32'h0020A423);
    chk("s_addr", addr, 32'h104);
    beat(4'd5, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    cyc();
    chk("b_wdata", wdata, 32'hFE208EE3);
    beat(4'd8, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    cyc();
    chk("u_wdata", wdata, 32'h123452B7);
    beat(4'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    cyc();
    chk("j_wdata", wdata, 32'h008000EF);
    chk("j_addr", addr, 32'h110);
    valid = 1'b0;
    cyc();

    // Backpressure: held write stays stable, second beat waits
    wr_ready = 1'b0;
    beat(4'd3, 3'd2, 1'b0, 5'd7, 5'd8, 5'd0, 32'h7F0);
    cyc();
    a0 = addr; d0 = wdata; c0 = count;
    beat(4'd7, 3'd0, 1'b0, 5'd1, 5'd6, 5'd0, 32'h10);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_we", {31'd0, we}, 32'd1);
      chk("bp_addr", addr, a0);
      chk("bp_wdata", wdata, d0);
      chk("bp_ready", {31'd0, ready}, 32'd0);
      chk("bp_count", {16'd0, count}, {16'd0, c0});
    end
    wr_ready = 1'b1;
    cyc();
    valid = 1'b0;
    chk("bp2_wdata", wdata,
        ref_enc(4'd7, 3'd0, 1'b0, 5'd1, 5'd6, 5'd0, 32'h10));
    chk("bp2_addr", addr, a0 + 32'd4);
    chk("bp2_count", {16'd0, count}, {16'd0, c0} + 32'd1);
    cyc();

    // Illegal class
    c0 = count;
    beat(4'd15, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd1);
    cyc();
    valid = 1'b0;
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_we", {31'd0, we}, 32'd0);
    chk("ill_count", {16'd0, count}, {16'd0, c0});
    cyc();

    // Stop with a pending write drains before idling
    wr_ready = 1'b0;
    beat(4'd1, 3'd0, 1'b1, 5'd4, 5'd5, 5'd6, 32'd0);
    cyc();
    valid = 1'b0; stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("dr_busy0", {31'd0, busy}, 32'd1);
    chk("dr_we0", {31'd0, we}, 32'd1);
    cyc();
    chk("dr_busy1", {31'd0, busy}, 32'd1);
    wr_ready = 1'b1;
    cyc();
    chk("dr_busy2", {31'd0, busy}, 32'd1);
    cyc();
    chk("dr_idle", {31'd0, busy}, 32'd0);

    // Address wrap at top of memory
    start = 1'b1; base = 32'hFFFFFFFC;
    cyc();
    start = 1'b0;
    beat(4'd9, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'hABCDE000);
    cyc();
    chk("wrap_a0", addr, 32'hFFFFFFFC);
    beat(4'd2, 3'd1, 1'b0, 5'd2, 5'd2, 5'd0, 32'd3);
    cyc();
    chk("wrap_a1", addr, 32'h0);
    valid = 1'b0; stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      start    = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      base     = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(0, 15) == 0) base = 32'hFFFFFFF8;
      valid    = ($urandom_range(0, 3) != 0);
      code     = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 15) == 0) code = 4'($urandom);
      f3       = 3'($urandom);
      f7       = 1'($urandom);
      rd       = 5'($urandom);
      rs1      = 5'($urandom);
      rs2      = 5'($urandom);
      imm      = $urandom;
      wr_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end

    // Reset in the middle of a held write
    valid = 1'b0; start = 1'b0; stop = 1'b0; wr_ready = 1'b1;
    repeat (4) cyc();
    start = 1'b1; base = 32'h200;
    cyc();
    start = 1'b0; wr_ready = 1'b0;
    beat(4'd1, 3'd7, 1'b0, 5'd9, 5'd9, 5'd9, 32'd0);
    cyc();
    valid = 1'b0;
    cyc();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_we", {31'd0, we}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ready", {31'd0, ready}, 32'd0);
    chk("mr_addr", addr, 32'd0);
    chk("mr_wdata", wdata, 32'd0);
    chk("mr_count", {16'd0, count}, 32'd0);
    chk("mr_err", {31'd0, err}, 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1; wr_ready = 1'b1;
    repeat (2) cyc();
    chk("mr_stay_idle", {31'd0, busy}, 32'd0);
    chk("mr_no_we", {31'd0, we}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
